// File: rtl/pc_clk_pkg.sv
// pc_clk_pkg: shared defaults and helpers for the PC-core clock generator.
`default_nettype none

package pc_clk_pkg;

  localparam int OSC_DIV_DEF    = 7;
  localparam int OSC_HIGH_DEF   = 3;
  localparam int CLK_DIV_DEF    = 3;
  localparam int PCLK_DIV_DEF   = 2;
  localparam int VCLK_DIV_DEF   = 5;
  localparam int VCLK_HIGH_DEF  = 2;
  localparam int RESET_HOLD_DEF = 4;

  typedef enum logic {
    RDY_TWO_STAGE = 1'b0,
    RDY_ONE_STAGE = 1'b1
  } rdy_mode_e;

  function automatic int cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkgen_8284p_clkdiv.sv
// clkdiv_en: enabled modulo-DIV counter with a registered level (high for the first HIGH counts).
`default_nettype none

module clkdiv_en
  import pc_clk_pkg::*;
#(
  parameter int DIV  = 7,
  parameter int HIGH = 3
) (
  input  logic fclk,
  input  logic reset_n,
  input  logic en,
  output logic level,
  output logic wrap
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST   = W'(DIV - 1);
  localparam logic [W-1:0] HIGH_C = W'(HIGH);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic         run;

  // wrap marks every edge on which the count (re)enters 0, including the start edge
  always_comb begin
    wrap    = ~run | (en & (cnt == LAST));
    cnt_nxt = cnt;
    if (run && en) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      run   <= 1'b0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      run   <= 1'b1;
      level <= (cnt_nxt < HIGH_C);
    end
  end

endmodule

`default_nettype wire

// File: rtl/clkgen_8284p.sv
// clkgen_8284p: osc/clk/pclk/vclk generation, clk edge strobes, READY synchroniser
// and clk-aligned reset stretcher for the PC core.
`default_nettype none

module clkgen_8284p
  import pc_clk_pkg::*;
#(
  parameter int OSC_DIV    = OSC_DIV_DEF,
  parameter int OSC_HIGH   = OSC_HIGH_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int PCLK_DIV   = PCLK_DIV_DEF,
  parameter int VCLK_DIV   = VCLK_DIV_DEF,
  parameter int VCLK_HIGH  = VCLK_HIGH_DEF,
  parameter int RESET_HOLD = RESET_HOLD_DEF
) (
  input  logic       fclk,
  input  logic       reset_n,
  input  logic       res_in_n,
  input  logic [1:0] rdy,
  input  logic [1:0] aen_n,
  input  logic       async_n,
  output logic       osc,
  output logic       clk,
  output logic       pclk,
  output logic       vclk,
  output logic       clk_rise,
  output logic       clk_fall,
  output logic       ready,
  output logic       reset
);

  localparam int HW = cnt_w(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD);

  logic          osc_wrap;
  logic          clk_wrap;
  logic          pclk_wrap;
  logic          vclk_wrap;
  logic          fall_nxt;
  logic          rq;
  logic          stage1;
  logic          res_s1;
  logic          res_req;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_dec;
  rdy_mode_e     mode;

  clkdiv_en #(.DIV(OSC_DIV), .HIGH(OSC_HIGH)) u_osc (
    .fclk(fclk), .reset_n(reset_n), .en(1'b1), .level(osc), .wrap(osc_wrap)
  );

  clkdiv_en #(.DIV(CLK_DIV), .HIGH(1)) u_clk (
    .fclk(fclk), .reset_n(reset_n), .en(osc_wrap), .level(clk), .wrap(clk_wrap)
  );

  clkdiv_en #(.DIV(PCLK_DIV), .HIGH(PCLK_DIV / 2)) u_pclk (
    .fclk(fclk), .reset_n(reset_n), .en(clk_wrap), .level(pclk), .wrap(pclk_wrap)
  );

  clkdiv_en #(.DIV(VCLK_DIV), .HIGH(VCLK_HIGH)) u_vclk (
    .fclk(fclk), .reset_n(reset_n), .en(1'b1), .level(vclk), .wrap(vclk_wrap)
  );

  // clk is high only while its count is 0, so an osc wrap during clk high is the fall
  assign fall_nxt = clk & osc_wrap;
  assign rq       = |(rdy & ~aen_n);
  assign mode     = rdy_mode_e'(async_n);
  assign hold_dec = (hold_cnt == '0) ? '0 : hold_cnt - HW'(1);

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      clk_rise <= 1'b0;
      clk_fall <= 1'b0;
      stage1   <= 1'b0;
      ready    <= 1'b0;
    end else begin
      clk_rise <= clk_wrap;
      clk_fall <= fall_nxt;
      if (clk_wrap) begin
        stage1 <= rq;
      end
      if (fall_nxt) begin
        ready <= (mode == RDY_ONE_STAGE) ? rq : stage1;
      end
    end
  end

  // Sync flops reset low so hold_cnt is reloaded right after reset_n releases
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      res_s1   <= 1'b0;
      res_req  <= 1'b0;
      hold_cnt <= '0;
      reset    <= 1'b1;
    end else begin
      res_s1  <= res_in_n;
      res_req <= res_s1;
      if (!res_req) begin
        hold_cnt <= HOLD_LOAD;
        if (fall_nxt) begin
          reset <= 1'b1;
        end
      end else if (fall_nxt) begin
        hold_cnt <= hold_dec;
        reset    <= (hold_dec != '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/clkgen_8284p.md
# clkgen_8284p

Parametrised system clock generator for the PC core, the successor to the fixed-ratio 8284A model. From the single fast fabric clock it derives the oscillator, CPU clock (1/3 duty), peripheral clock and video clock as registered levels, plus single-cycle CPU-clock edge strobes. It also provides a two-channel READY synchroniser with selectable one- or two-stage mode, and a stretched, CPU-clock-aligned RESET. It feeds the 8088 core, bus controller, PIT and video blocks.

## Interface
Parameters:
- OSC_DIV, 7: fclk cycles per osc period (≥2)
- OSC_HIGH, 3: fclk cycles osc is high (1..OSC_DIV-1)
- CLK_DIV, 3: osc periods per clk period (≥2); clk high for the first osc period
- PCLK_DIV, 2: clk periods per pclk period (≥2); pclk high for the first PCLK_DIV/2
- VCLK_DIV, 5: fclk cycles per vclk period (≥2)
- VCLK_HIGH, 2: fclk cycles vclk is high (1..VCLK_DIV-1)
- RESET_HOLD, 4: clk periods reset stays high after res_in_n releases (≥1)

Ports:
- fclk  in  1  fabric clock; every register is clocked on its rising edge
- reset_n  in  1  asynchronous, active-low block reset
- res_in_n  in  1  external reset request (power-good / button), asynchronous, active-low
- rdy  in  2  READY requests, channels 1 and 2
- aen_n  in  2  per-channel address enable, active-low
- async_n  in  1  0 = two-stage READY synchronisation; 1 = one-stage
- osc, clk, pclk, vclk  out  1 each  registered clock levels
- clk_rise, clk_fall  out  1 each  high for the one fclk cycle in which clk has just gone to 1 / 0
- ready  out  1  synchronised READY to the CPU
- reset  out  1  active-high system reset, aligned to a clk fall

## Operation
- While reset_n = 0: all counters are 0; osc, clk, pclk, vclk, clk_rise, clk_fall and ready are 0; reset is 1.
- osc_cnt counts 0..OSC_DIV-1 every fclk and wraps. osc = (osc_cnt < OSC_HIGH).
- clk_cnt advances when osc_cnt wraps and runs 0..CLK_DIV-1. clk = (clk_cnt == 0).
- pclk_cnt advances on each clk rise and runs 0..PCLK_DIV-1. pclk = (pclk_cnt < PCLK_DIV/2).
- vclk_cnt is free-running, independent of the others: 0..VCLK_DIV-1. vclk = (vclk_cnt < VCLK_HIGH).
- Every output is registered from the next-state count. The first fclk edge after reset_n releases therefore shows count 0: osc = clk = pclk = vclk = 1 and clk_rise = 1.
- Qualified READY: rq = (rdy[0] & ~aen_n[0]) | (rdy[1] & ~aen_n[1]).
- async_n = 0:
  - stage1 samples rq on the edge that produces clk_rise.
  - ready samples stage1 on the edge that produces clk_fall.
- async_n = 1: ready samples rq directly on the edge that produces clk_fall.
- async_n is sampled at the same point as ready. A mid-run change takes effect at the next clk fall.
- Reset stretcher:
  - res_in_n passes through a 2-flop synchroniser.
  - While the synchronised request is low, hold_cnt loads RESET_HOLD, and reset sets to 1 at the next clk_fall edge.
  - Once the request is high, hold_cnt decrements on each clk_fall edge.
  - reset clears on the clk_fall edge where hold_cnt reaches 0.
  - A re-assertion mid-count reloads hold_cnt.
- reset_n and res_in_n both low: reset stays 1. hold_cnt is reloaded once reset_n releases.

## Timing
- With default parameters:
  - clk period = 21 fclk, with 7 high and 14 low.
  - pclk period = 42 fclk.
  - vclk period = 5 fclk (2 high).
- Counting fclk edges after reset_n release from 1:
  - clk_rise at edges 1, 22, 43, …
  - clk_fall at edges 8, 29, …
- READY latency:
  - One-stage: rq is captured at the next clk fall, so 1 to 21 fclk.
  - Two-stage: rq needs a clk rise and then the following clk fall.
- ready changes only on clk_fall edges. reset changes only on clk_fall edges, apart from the asynchronous assertion by reset_n.
- Counter widths are $clog2(DIV) each. Wrap is exact, with no extra count at the terminal value.

## Structure
- Shared package pc_clk_pkg holds:
  - default divider constants;
  - a cnt_w(div) width function.
- Sub-module clkdiv_en, instanced for osc, clk, pclk and vclk:
  - parameters DIV and HIGH;
  - inputs fclk, reset_n and an advance enable;
  - outputs the registered level and a wrap pulse.
- The READY and reset logic stays in the top module.

## Test plan
- Release reset_n with defaults → clk_rise at edges 1 and 22; clk_fall at edge 8; osc high 3 of every 7; vclk high 2 of every 5; pclk high 21 of every 42.
- Override OSC_DIV = 4, OSC_HIGH = 2, CLK_DIV = 4 → clk period 16, high 4; clk_rise at edges 1 and 17.
- async_n = 1, rdy[0] = 1, aen_n[0] = 0 raised at edge 10 → ready = 1 at edge 29; with aen_n[0] = 1 instead → ready stays 0.
- async_n = 0, same stimulus at edge 10 → stage1 set at edge 22, ready = 1 at edge 29; stimulus at edge 23 instead → ready = 1 at edge 50.
- res_in_n low from edge 30 to 60 with RESET_HOLD = 4 → reset = 1 at edge 50; reset clears at the clk_fall edge where hold_cnt reaches 0.
- Assert reset_n mid-run at edge 15 → all outputs 0 and reset = 1 within that cycle; after release, the sequence restarts at count 0.
